// File: rtl/gpio_pkg.sv
// Shared constants for the memory-mapped GPIO block: data width and register offsets.
package gpio_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;

    localparam logic [ADDR_W-1:0] GPIO_LED = 3'd0;
    localparam logic [ADDR_W-1:0] GPIO_SET = 3'd1;
    localparam logic [ADDR_W-1:0] GPIO_CLR = 3'd2;
    localparam logic [ADDR_W-1:0] GPIO_TGL = 3'd3;
    localparam logic [ADDR_W-1:0] GPIO_BUT = 3'd4;
    localparam logic [ADDR_W-1:0] GPIO_PEV = 3'd5;
    localparam logic [ADDR_W-1:0] GPIO_REV = 3'd6;
    localparam logic [ADDR_W-1:0] GPIO_DEB = 3'd7;

endpackage

// File: rtl/gpio_debounce.sv
// One button channel: 2-flop synchroniser, consecutive-cycle debounce counter,
// debounced level and single-cycle rise/fall indications aligned with the level update.
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int unsigned DEB_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             but_raw,
    input  logic [DEB_W-1:0] limit,
    output logic             level,
    output logic             rise_c,
    output logic             fall_c
);

    localparam int unsigned CNT_W = DEB_W + 1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             s_c;
    logic [DEB_W-1:0] eff_limit_c;
    logic [CNT_W-1:0] cnt_inc_c;

    always_comb begin
        sync1_d     = but_raw;
        sync2_d     = sync1_q;
        s_c         = ~sync2_q;
        eff_limit_c = (limit == '0) ? DEB_W'(1) : limit;
        cnt_inc_c   = {1'b0, cnt_q} + CNT_W'(1);
        cnt_d       = '0;
        level_d     = level_q;
        rise_c      = 1'b0;
        fall_c      = 1'b0;
        // >= rather than == so a limit lowered mid-count flips on the next compare
        if (s_c != level_q) begin
            if (cnt_inc_c >= {1'b0, eff_limit_c}) begin
                level_d = s_c;
                rise_c  = s_c;
                fall_c  = ~s_c;
            end else begin
                cnt_d = cnt_q + DEB_W'(1);
            end
        end
    end

    // Synchroniser resets to released so reset deassertion never looks like a press
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO: LED register with set/clear/toggle aliases, debounced buttons,
// sticky press/release event flags with W1C, programmable debounce limit and irq.
module gpio_mmio
    import gpio_pkg::*;
#(
    parameter int unsigned N_LED     = 2,
    parameter int unsigned N_BUT     = 2,
    parameter int unsigned DEB_W     = 16,
    parameter int unsigned DEB_RESET = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              load,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic [N_BUT-1:0]  but,
    output logic [N_LED-1:0]  led,
    output logic              irq
);

    logic [N_LED-1:0] led_q, led_d;
    logic [N_BUT-1:0] pev_q, pev_d;
    logic [N_BUT-1:0] rev_q, rev_d;
    logic [DEB_W-1:0] lim_q, lim_d;
    logic [N_BUT-1:0] level;
    logic [N_BUT-1:0] rise_c;
    logic [N_BUT-1:0] fall_c;
    logic [N_LED-1:0] wd_led_c;
    logic [N_BUT-1:0] wd_but_c;
    logic             unused_wdata_c;

    for (genvar i = 0; i < N_BUT; i++) begin : g_deb
        gpio_debounce #(
            .DEB_W (DEB_W)
        ) u_deb (
            .clk     (clk),
            .reset   (reset),
            .but_raw (but[i]),
            .limit   (lim_q),
            .level   (level[i]),
            .rise_c  (rise_c[i]),
            .fall_c  (fall_c[i])
        );
    end

    assign unused_wdata_c = ^wdata;

    always_comb begin
        wd_led_c = wdata[N_LED-1:0];
        wd_but_c = wdata[N_BUT-1:0];
        led_d    = led_q;
        pev_d    = pev_q;
        rev_d    = rev_q;
        lim_d    = lim_q;
        if (load) begin
            case (addr)
                GPIO_LED: led_d = wd_led_c;
                GPIO_SET: led_d = led_q | wd_led_c;
                GPIO_CLR: led_d = led_q & ~wd_led_c;
                GPIO_TGL: led_d = led_q ^ wd_led_c;
                GPIO_PEV: pev_d = pev_q & ~wd_but_c;
                GPIO_REV: rev_d = rev_q & ~wd_but_c;
                GPIO_DEB: lim_d = wdata[DEB_W-1:0];
                default:  ;
            endcase
        end
        // Hardware set is applied after the clear so a coincident event wins
        pev_d = pev_d | rise_c;
        rev_d = rev_d | fall_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q <= '0;
            pev_q <= '0;
            rev_q <= '0;
            lim_q <= DEB_W'(DEB_RESET);
        end else begin
            led_q <= led_d;
            pev_q <= pev_d;
            rev_q <= rev_d;
            lim_q <= lim_d;
        end
    end

    // Zero-latency read mux; narrow registers zero-extend
    always_comb begin
        rdata = '0;
        case (addr)
            GPIO_LED, GPIO_SET, GPIO_CLR, GPIO_TGL: rdata = DATA_W'(led_q);
            GPIO_BUT: rdata = DATA_W'(level);
            GPIO_PEV: rdata = DATA_W'(pev_q);
            GPIO_REV: rdata = DATA_W'(rev_q);
            GPIO_DEB: rdata = DATA_W'(lim_q);
            default:  rdata = '0;
        endcase
    end

    assign led = led_q;
    assign irq = (|pev_q) | (|rev_q);

endmodule

// File: tb/tb_gpio_mmio.sv
// Self-checking bench for gpio_mmio: directed scenarios plus randomized traffic
// checked against a pin-history based reference model.
`timescale 1ns/1ps
module tb_gpio_mmio;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  addr;
    logic        load;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [1:0]  but;
    logic [1:0]  led;
    logic        irq;

    int checks = 0;
    int errors = 0;

    gpio_mmio #(
        .N_LED     (2),
        .N_BUT     (2),
        .DEB_W     (16),
        .DEB_RESET (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .load  (load),
        .wdata (wdata),
        .rdata (rdata),
        .but   (but),
        .led   (led),
        .irq   (irq)
    );

    always #10 clk = ~clk;

    // Reference model: level flips once the last eff_limit synchronised samples all differ.
    logic [1:0]  m_led, m_pev, m_rev, m_level;
    logic [15:0] m_lim;
    logic [1:0]  pin_hist[$];

    function automatic logic [1:0] pin_at(int idx);
        if (idx < 0) return 2'b11;
        return pin_hist[idx];
    endfunction

    function automatic logic [15:0] model_rd(logic [2:0] a);
        case (a)
            3'd0, 3'd1, 3'd2, 3'd3: return {14'b0, m_led};
            3'd4: return {14'b0, m_level};
            3'd5: return {14'b0, m_pev};
            3'd6: return {14'b0, m_rev};
            default: return m_lim;
        endcase
    endfunction

    task automatic model_reset();
        m_led   = 2'b00;
        m_pev   = 2'b00;
        m_rev   = 2'b00;
        m_level = 2'b00;
        m_lim   = 16'd8;
        pin_hist.delete();
    endtask

    task automatic model_step();
        int n;
        int eff;
        logic [1:0] rise, fall, s;
        bit flip;
        pin_hist.push_back(but);
        n    = pin_hist.size();
        eff  = (m_lim == 16'd0) ? 1 : int'(m_lim);
        rise = 2'b00;
        fall = 2'b00;
        for (int b = 0; b < 2; b++) begin
            flip = 1'b1;
            for (int j = 0; j < eff; j++) begin
                s = ~pin_at(n - 3 - j);
                if (s[b] == m_level[b]) begin
                    flip = 1'b0;
                    break;
                end
            end
            if (flip) begin
                if (m_level[b]) fall[b] = 1'b1;
                else            rise[b] = 1'b1;
            end
        end
        if (load) begin
            case (addr)
                3'd0: m_led = wdata[1:0];
                3'd1: m_led = m_led | wdata[1:0];
                3'd2: m_led = m_led & ~wdata[1:0];
                3'd3: m_led = m_led ^ wdata[1:0];
                3'd5: m_pev = m_pev & ~wdata[1:0];
                3'd6: m_rev = m_rev & ~wdata[1:0];
                3'd7: m_lim = wdata;
                default: ;
            endcase
        end
        m_pev   = m_pev | rise;
        m_rev   = m_rev | fall;
        m_level = m_level ^ (rise | fall);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        load  = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        load  = 1'b0;
    endtask

    task automatic test_reset();
        but   = 2'b11;
        load  = 1'b0;
        addr  = 3'd0;
        wdata = 16'h0;
        reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (20) tick();
        for (int a = 4; a <= 6; a++) begin
            addr = 3'(a);
            #1;
            checks++;
            if (rdata !== 16'h0000) begin
                $display("FAIL reset_reg addr=%0d got=%h exp=0000", a, rdata);
                errors++;
            end
        end
        addr = 3'd7;
        #1;
        checks++;
        if (rdata !== 16'd8) begin
            $display("FAIL reset_deb_limit got=%h exp=0008", rdata);
            errors++;
        end
        checks++;
        if (led !== 2'b00 || irq !== 1'b0) begin
            $display("FAIL reset_outputs led=%b irq=%b exp led=00 irq=0", led, irq);
            errors++;
        end
    endtask

    task automatic test_debounce();
        wr(3'd7, 16'd4);
        addr = 3'd7;
        #1;
        checks++;
        if (rdata !== 16'd4) begin
            $display("FAIL deb_limit_wr got=%h exp=0004", rdata);
            errors++;
        end
        but[0] = 1'b0;
        repeat (5) tick();
        addr = 3'd4;
        #1;
        checks++;
        if (rdata !== 16'h0000) begin
            $display("FAIL deb_early got=%h exp=0000", rdata);
            errors++;
        end
        tick();
        addr = 3'd4;
        #1;
        checks++;
        if (rdata !== 16'h0001 || rdata !== model_rd(3'd4)) begin
            $display("FAIL deb_level got=%h exp=0001", rdata);
            errors++;
        end
        addr = 3'd5;
        #1;
        checks++;
        if (rdata !== 16'h0001 || irq !== 1'b1) begin
            $display("FAIL deb_press_ev got=%h irq=%b exp=0001 irq=1", rdata, irq);
            errors++;
        end
    endtask

    task automatic test_glitch();
        but[1] = 1'b0;
        repeat (3) tick();
        but[1] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            addr = 3'd4;
            #1;
            checks++;
            if (rdata !== 16'h0001) begin
                $display("FAIL glitch_level cyc=%0d got=%h exp=0001", c, rdata);
                errors++;
            end
            addr = 3'd5;
            #1;
            checks++;
            if (rdata !== 16'h0001) begin
                $display("FAIL glitch_press_ev cyc=%0d got=%h exp=0001", c, rdata);
                errors++;
            end
        end
    endtask

    task automatic test_event_clear();
        wr(3'd5, 16'h0001);
        addr = 3'd5;
        #1;
        checks++;
        if (rdata !== 16'h0000 || irq !== 1'b0) begin
            $display("FAIL ev_w1c got=%h irq=%b exp=0000 irq=0", rdata, irq);
            errors++;
        end
        but[0] = 1'b1;
        repeat (5) tick();
        addr = 3'd6;
        #1;
        checks++;
        if (rdata !== 16'h0000) begin
            $display("FAIL rel_early got=%h exp=0000", rdata);
            errors++;
        end
        tick();
        addr = 3'd6;
        #1;
        checks++;
        if (rdata !== 16'h0001 || irq !== 1'b1) begin
            $display("FAIL rel_ev got=%h irq=%b exp=0001 irq=1", rdata, irq);
            errors++;
        end
        but[0] = 1'b0;
        repeat (5) tick();
        wr(3'd5, 16'h0001);
        addr = 3'd5;
        #1;
        checks++;
        if (rdata !== 16'h0001 || rdata !== model_rd(3'd5)) begin
            $display("FAIL set_wins got=%h exp=0001", rdata);
            errors++;
        end
        wr(3'd5, 16'h0003);
        wr(3'd6, 16'h0003);
        #1;
        checks++;
        if (irq !== 1'b0) begin
            $display("FAIL ev_all_clear irq=%b exp=0", irq);
            errors++;
        end
    endtask

    task automatic test_led();
        logic [2:0]  la[6];
        logic [15:0] ld[6];
        logic [1:0]  le[6];
        la = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4};
        ld = '{16'h0001, 16'h0002, 16'h0001, 16'h0003, 16'h0000, 16'hFFFF};
        le = '{2'b01, 2'b11, 2'b10, 2'b01, 2'b01, 2'b01};
        for (int k = 0; k < 6; k++) begin
            wr(la[k], ld[k]);
            checks++;
            if (led !== le[k]) begin
                $display("FAIL led_op step=%0d led=%b exp=%b", k, led, le[k]);
                errors++;
            end
        end
        addr = 3'd0;
        #1;
        checks++;
        if (rdata !== 16'h0001) begin
            $display("FAIL led_read got=%h exp=0001", rdata);
            errors++;
        end
        addr = 3'd4;
        #1;
        checks++;
        if (rdata !== 16'h0001) begin
            $display("FAIL but_ro got=%h exp=0001", rdata);
            errors++;
        end
    endtask

    task automatic test_async_reset();
        but = 2'b11;
        repeat (12) tick();
        wr(3'd7, 16'd8);
        wr(3'd0, 16'h0003);
        but[0] = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        model_reset();
        #2;
        checks++;
        if (led !== 2'b00 || irq !== 1'b0) begin
            $display("FAIL async_rst_out led=%b irq=%b exp led=00 irq=0", led, irq);
            errors++;
        end
        addr = 3'd4;
        #1;
        checks++;
        if (rdata !== 16'h0000) begin
            $display("FAIL async_rst_level got=%h exp=0000", rdata);
            errors++;
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (9) tick();
        addr = 3'd4;
        #1;
        checks++;
        if (rdata !== 16'h0000) begin
            $display("FAIL async_rst_early got=%h exp=0000", rdata);
            errors++;
        end
        tick();
        addr = 3'd4;
        #1;
        checks++;
        if (rdata !== 16'h0001 || rdata !== model_rd(3'd4)) begin
            $display("FAIL async_rst_press got=%h exp=0001", rdata);
            errors++;
        end
    endtask

    task automatic test_random();
        wr(3'd7, 16'd3);
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 3) == 0) but[0] = ~but[0];
            if ($urandom_range(0, 3) == 0) but[1] = ~but[1];
            load  = ($urandom_range(0, 2) == 0);
            addr  = 3'($urandom_range(0, 7));
            wdata = 16'($urandom);
            if (addr == 3'd7) wdata = 16'($urandom_range(0, 5));
            tick();
            load = 1'b0;
            for (int a = 0; a < 8; a++) begin
                addr = 3'(a);
                #1;
                checks++;
                if (rdata !== model_rd(3'(a))) begin
                    $display("FAIL rand_rd cyc=%0d addr=%0d got=%h exp=%h", c, a, rdata, model_rd(3'(a)));
                    errors++;
                end
            end
            checks++;
            if (led !== m_led || irq !== ((|m_pev) | (|m_rev))) begin
                $display("FAIL rand_out cyc=%0d led=%b irq=%b exp led=%b irq=%b", c, led, irq, m_led, (|m_pev) | (|m_rev));
                errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_glitch();
        test_event_clear();
        test_led();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
